fifo_burst_reader: RTL and testbench

- Read-side master for the team's FIFO. It drains a commanded burst of words from the FIFO and presents them downstream on a valid/ready stream.
- The FIFO has a 1-cycle registered read: rden sampled at posedge N gives rdata valid after posedge N.
- The block hides that latency with a credit scheme and a 2-entry output buffer, sustaining 1 word/cycle.
- Sits between a FIFO instance and a consumer (e.g. MAC/compute stage).

---
 rtl/fifo_rd_pkg.sv | 10 +
 rtl/skid_buf2.sv | 51 +++++
 rtl/fifo_burst_reader.sv | 89 ++++++++
 tb/tb_fifo_burst_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO burst reader.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO-ordered output buffer; head is presented while count is non-zero.
module skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign head   = (count != 2'd0) ? ent0 : '0;

  // The producer never pushes into a full buffer without a simultaneous pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count == 2'd0) ent0 <= push_data;
          else               ent1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a commanded burst from a 1-cycle-latency FIFO onto a valid/ready stream.
// Credits (buffer occupancy + in-flight read) keep at most two words outstanding.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_LEN    = 8,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rden,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  rd_state_t        state;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] out_cnt;
  logic             inflight;
  logic [1:0]       buf_cnt;
  logic             pop;
  logic [2:0]       credits_used;
  logic [2:0]       credits_free;

  assign pop          = m_valid && m_ready;
  assign credits_used = {1'b0, buf_cnt} + {2'b00, inflight};
  assign credits_free = 3'd2 + {2'b00, pop};

  assign fifo_rden = (state == RUN) && (issue_cnt != '0) && !fifo_empty &&
                     (credits_used < credits_free);

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign m_valid = (buf_cnt != 2'd0);
  assign m_last  = m_valid && (out_cnt == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      out_cnt   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_rden;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state     <= RUN;
              issue_cnt <= len;
              out_cnt   <= len;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (fifo_rden) issue_cnt <= issue_cnt - LEN_W'(1);
          if (pop) begin
            out_cnt <= out_cnt - LEN_W'(1);
            if (out_cnt == LEN_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  skid_buf2 #(.W(DATA_WIDTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .count     (buf_cnt),
    .head      (m_data)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scenario bench for fifo_burst_reader with a behavioural FIFO and stream scoreboard.
module tb_fifo_burst_reader;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, fifo_rden, m_valid, m_last;
  logic             fifo_empty = 1'b1;
  logic [7:0]       fifo_rdata = 8'h00;
  logic             m_ready = 1'b1;
  logic [7:0]       m_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  // behavioural FIFO
  logic [7:0] fifo_q[$];
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  int         fifo_reads = 0;
  int         rd_violation = 0;

  // per-burst observations
  logic [7:0] got_q[$];
  bit         last_q[$];
  logic [7:0] pre_q[$];
  int         sched_cyc[$];
  logic [7:0] sched_dat[$];
  int         inj_cyc = -1;
  int done_cnt, done_cyc, first_valid_cyc, last_pop_cyc, rden_cnt;
  int max_out, stable_err, busy_cnt;
  bit busy_at_done;

  fifo_burst_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .fifo_rden  (fifo_rden),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rden) begin
      if (fifo_q.size() == 0) rd_violation++;
      else begin
        fifo_rdata <= fifo_q.pop_front();
        fifo_reads++;
      end
    end
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic preload();
    foreach (pre_q[k]) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = pre_q[k];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issues one start and observes the burst; cycle c counts negedges after the start edge.
  task automatic run_burst(input int l, input int hold, input bit rand_ready, input int budget);
    logic [7:0] prev_data;
    bit prev_stall;
    prev_data = 8'h00; prev_stall = 1'b0;
    got_q.delete(); last_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; last_pop_cyc = -1;
    rden_cnt = 0; max_out = 0; stable_err = 0; busy_cnt = 0; busy_at_done = 1'b1;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(l); m_ready = 1'b1; wr_en = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = (c == inj_cyc);
      if (c == inj_cyc) len = 4'd2;
      wr_en = 1'b0;
      for (int k = 0; k < sched_cyc.size(); k++)
        if (sched_cyc[k] == c) begin wr_en = 1'b1; wr_data = sched_dat[k]; end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (first_valid_cyc >= 0 && c < first_valid_cyc + hold) m_ready = 1'b0;
      else if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
      #1;
      if (prev_stall && m_data !== prev_data) stable_err++;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (fifo_rden) rden_cnt++;
      if (busy) busy_cnt++;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        last_q.push_back(m_last);
        last_pop_cyc = c;
      end
      if (rden_cnt - got_q.size() > max_out) max_out = rden_cnt - got_q.size();
      if (done) begin done_cnt++; done_cyc = c; busy_at_done = busy; end
      if (done_cyc > 0 && c >= done_cyc + 2) break;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 4'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total_cnt++;
      if ({busy, done, m_valid, m_last, fifo_rden} !== 5'b0 || m_data !== 8'h00)
        $display("FAIL reset_outputs got busy/done/valid/last/rden=%b%b%b%b%b data=%h exp 00000 data=00",
                 busy, done, m_valid, m_last, fifo_rden, m_data);
      else pass_cnt++;
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(negedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL reset_release got busy=%b done=%b valid=%b exp 0 0 0", busy, done, m_valid);
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    logic [7:0] exp_q[$];
    bit ok;
    pre_q = '{8'h11, 8'h22, 8'h33}; exp_q = pre_q;
    preload();
    run_burst(3, 0, 1'b0, 40);
    ok = (got_q.size() == 3) && (last_q.size() == 3);
    for (int k = 0; k < got_q.size() && k < 3; k++)
      ok &= (got_q[k] === exp_q[k]) && (last_q[k] === (k == 2));
    total_cnt++;
    if (!ok) $display("FAIL nominal_data got=%p last=%p exp=%p last only on final", got_q, last_q, exp_q);
    else pass_cnt++;
    total_cnt++;
    if (first_valid_cyc !== 3) $display("FAIL nominal_latency got=%0d exp=3", first_valid_cyc);
    else pass_cnt++;
    total_cnt++;
    if (last_pop_cyc !== first_valid_cyc + 2 || done_cyc !== last_pop_cyc + 1 || done_cnt !== 1)
      $display("FAIL nominal_timing got last_pop=%0d done=%0d x%0d exp last_pop=%0d done=%0d x1",
               last_pop_cyc, done_cyc, done_cnt, first_valid_cyc + 2, first_valid_cyc + 3);
    else pass_cnt++;
    total_cnt++;
    if (rden_cnt !== 3) $display("FAIL nominal_rden got=%0d exp=3", rden_cnt);
    else pass_cnt++;
    total_cnt++;
    if (busy_cnt !== done_cyc - 1 || busy_at_done !== 1'b0)
      $display("FAIL nominal_busy got cycles=%0d at_done=%b exp cycles=%0d at_done=0",
               busy_cnt, busy_at_done, done_cyc - 1);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[$];
    bit ok;
    pre_q = '{8'h44, 8'h55, 8'h66, 8'h77}; exp_q = pre_q;
    preload();
    run_burst(4, 4, 1'b0, 60);
    ok = (got_q.size() == 4);
    for (int k = 0; k < got_q.size() && k < 4; k++)
      ok &= (got_q[k] === exp_q[k]) && (last_q[k] === (k == 3));
    total_cnt++;
    if (!ok) $display("FAIL bp_data got=%p last=%p exp=%p", got_q, last_q, exp_q);
    else pass_cnt++;
    total_cnt++;
    if (stable_err !== 0) $display("FAIL bp_hold got %0d changes exp 0", stable_err);
    else pass_cnt++;
    total_cnt++;
    if (max_out > 2 || rden_cnt !== 4)
      $display("FAIL bp_outstanding got max=%0d reads=%0d exp max<=2 reads=4", max_out, rden_cnt);
    else pass_cnt++;
    total_cnt++;
    if (fifo_q.size() !== 0 || done_cnt !== 1)
      $display("FAIL bp_end got fifo_left=%0d done=%0d exp 0 1", fifo_q.size(), done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    sched_cyc = '{5, 8}; sched_dat = '{8'hAA, 8'hBB};
    run_burst(2, 0, 1'b0, 60);
    sched_cyc.delete(); sched_dat.delete();
    total_cnt++;
    if (got_q.size() != 2 || got_q[0] !== 8'hAA || got_q[1] !== 8'hBB ||
        last_q[0] !== 1'b0 || last_q[1] !== 1'b1)
      $display("FAIL starve_data got=%p last=%p exp='{aa,bb} last='{0,1}", got_q, last_q);
    else pass_cnt++;
    total_cnt++;
    if (first_valid_cyc !== 8) $display("FAIL starve_first_valid got=%0d exp=8", first_valid_cyc);
    else pass_cnt++;
    total_cnt++;
    if (rd_violation !== 0) $display("FAIL starve_rden_empty got=%0d exp=0", rd_violation);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1 || done_cyc !== last_pop_cyc + 1)
      $display("FAIL starve_done got cnt=%0d cyc=%0d exp 1 %0d", done_cnt, done_cyc, last_pop_cyc + 1);
    else pass_cnt++;
  endtask

  task automatic test_zero_and_busy();
    logic [7:0] exp_q[$];
    bit ok;
    int reads0;
    reads0 = fifo_reads;
    run_burst(0, 0, 1'b0, 20);
    total_cnt++;
    if (done_cyc !== 1 || done_cnt !== 1 || rden_cnt !== 0 || busy_cnt !== 0 || fifo_reads !== reads0)
      $display("FAIL zero_len got done_cyc=%0d cnt=%0d rden=%0d busy=%0d exp 1 1 0 0",
               done_cyc, done_cnt, rden_cnt, busy_cnt);
    else pass_cnt++;
    pre_q.delete();
    for (int k = 0; k < 4; k++) pre_q.push_back(8'($urandom));
    exp_q = pre_q;
    preload();
    inj_cyc = 3;
    run_burst(4, 0, 1'b0, 60);
    inj_cyc = -1;
    ok = (got_q.size() == 4);
    for (int k = 0; k < got_q.size() && k < 4; k++) ok &= (got_q[k] === exp_q[k]);
    total_cnt++;
    if (!ok || done_cnt !== 1 || rden_cnt !== 4)
      $display("FAIL start_ignored got=%p done=%0d rden=%0d exp=%p done=1 rden=4",
               got_q, done_cnt, rden_cnt, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    bit ok;
    int l;
    for (int t = 0; t < 6; t++) begin
      l = $urandom_range(1, 8);
      pre_q.delete();
      for (int k = 0; k < l; k++) pre_q.push_back(8'($urandom));
      exp_q = pre_q;
      preload();
      run_burst(l, $urandom_range(0, 3), 1'b1, 400);
      ok = (got_q.size() == l);
      for (int k = 0; k < got_q.size() && k < l; k++)
        ok &= (got_q[k] === exp_q[k]) && (last_q[k] === (k == l - 1));
      total_cnt++;
      if (!ok) $display("FAIL rand_data[%0d] got=%p last=%p exp=%p", t, got_q, last_q, exp_q);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt !== 1 || done_cyc !== last_pop_cyc + 1 || rden_cnt !== l || max_out > 2 ||
          stable_err !== 0 || fifo_q.size() !== 0)
        $display("FAIL rand_ctrl[%0d] got done=%0d@%0d rden=%0d max=%0d unstable=%0d left=%0d exp 1@%0d %0d <=2 0 0",
                 t, done_cnt, done_cyc, rden_cnt, max_out, stable_err, fifo_q.size(), last_pop_cyc + 1, l);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp_q[$];
    logic [7:0] first2[$];
    bit ok;
    int pops;
    pre_q.delete();
    for (int k = 0; k < 8; k++) pre_q.push_back(8'($urandom));
    preload();
    pops = 0;
    @(negedge clk); start = 1'b1; len = 4'd5; m_ready = 1'b1;
    for (int c = 1; c <= 40 && pops < 2; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (m_valid && m_ready) begin pops++; first2.push_back(m_data); end
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    total_cnt++;
    if (first2.size() != 2 || first2[0] !== pre_q[0] || first2[1] !== pre_q[1])
      $display("FAIL midrst_pre got=%p exp first two of %p", first2, pre_q);
    else pass_cnt++;
    total_cnt++;
    if ({busy, done, m_valid, m_last, fifo_rden} !== 5'b0 || m_data !== 8'h00)
      $display("FAIL midrst_outputs got busy/done/valid/last/rden=%b%b%b%b%b data=%h exp 00000 data=00",
               busy, done, m_valid, m_last, fifo_rden, m_data);
    else pass_cnt++;
    exp_q.delete();
    for (int k = 0; k < 3 && k < fifo_q.size(); k++) exp_q.push_back(fifo_q[k]);
    run_burst(3, 0, 1'b0, 40);
    ok = (got_q.size() == 3) && (exp_q.size() == 3);
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) ok &= (got_q[k] === exp_q[k]);
    total_cnt++;
    if (!ok || done_cnt !== 1)
      $display("FAIL midrst_next got=%p done=%0d exp=%p done=1", got_q, done_cnt, exp_q);
    else pass_cnt++;
    @(negedge clk);
    fifo_q.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_starvation();
    test_zero_and_busy();
    test_random();
    test_mid_reset();
    total_cnt++;
    if (rd_violation !== 0) $display("FAIL rden_while_empty got=%0d exp=0", rd_violation);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
